// File: rtl/liteic_slave_read_arbiter.sv
// rtl/liteic_slave_read_arbiter.sv - QoS/age/round-robin read arbiter for one shared slave slot
//
// Purpose: lets NUM_MASTERS masters share one slave read port, with only one
// read outstanding at the slave at any time. The FSM runs IDLE -> ADDR -> RESP -> IDLE.
// Ports:
//   clk_i, rstn_i                      clock, asynchronous active-low reset
//   mst_reqst_val_i/addr_i/qos_i/rdy_o per-master AR channel (addr/qos flattened, master i at slice i)
//   mst_resp_val_o/rdy_i/data_o        per-master R channel (data is broadcast)
//   slv_ar_valid_o/ready_i/addr_o      slave AR channel
//   slv_r_valid_i/ready_o/data_i       slave R channel
//   grant_o                            one-hot current owner, zero in IDLE
module liteic_slave_read_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int RDATA_WIDTH = 34,
  parameter int AGE_LIMIT   = 8
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic [NUM_MASTERS-1:0]            mst_reqst_val_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] mst_reqst_addr_i,
  input  logic [NUM_MASTERS*4-1:0]          mst_reqst_qos_i,
  output logic [NUM_MASTERS-1:0]            mst_reqst_rdy_o,
  output logic [NUM_MASTERS-1:0]            mst_resp_val_o,
  input  logic [NUM_MASTERS-1:0]            mst_resp_rdy_i,
  output logic [RDATA_WIDTH-1:0]            mst_resp_data_o,
  output logic                              slv_ar_valid_o,
  input  logic                              slv_ar_ready_i,
  output logic [ADDR_WIDTH-1:0]             slv_ar_addr_o,
  input  logic                              slv_r_valid_i,
  output logic                              slv_r_ready_o,
  input  logic [RDATA_WIDTH-1:0]            slv_r_data_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IDX_W-1:0]       r_gidx;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [3:0]             r_age [NUM_MASTERS];

  logic [4:0]             w_prio [NUM_MASTERS];
  logic [IDX_W-1:0]       w_win_idx;
  logic [IDX_W-1:0]       w_cand;
  logic [IDX_W:0]         w_sum;
  logic [4:0]             w_best;
  logic                   w_found;
  logic                   w_any_req;
  logic                   w_r_hs;
  logic [IDX_W-1:0]       w_rr_nxt;

  assign w_any_req = |mst_reqst_val_i;
  assign w_r_hs    = (r_state == S_RESP) && slv_r_valid_i && mst_resp_rdy_i[r_gidx];
  assign w_rr_nxt  = (r_gidx == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_gidx + 1'b1;
  assign grant_o   = r_grant;

  // A saturated age counter lifts the requester above every QoS level (16 > 15).
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_prio[i] = (r_age[i] == 4'(AGE_LIMIT)) ? 5'd16 : {1'b0, mst_reqst_qos_i[i*4 +: 4]};
    end
  end

  // Scan in round-robin order from r_rr_ptr; only a strictly higher priority
  // replaces the current pick, so the first candidate in rr order wins ties.
  always_comb begin
    w_win_idx = '0;
    w_best    = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_MASTERS)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_MASTERS);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (mst_reqst_val_i[w_cand] && (!w_found || (w_prio[w_cand] > w_best))) begin
        w_found   = 1'b1;
        w_best    = w_prio[w_cand];
        w_win_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)      w_state_nxt = S_ADDR;
      S_ADDR:  if (slv_ar_ready_i) w_state_nxt = S_RESP;
      S_RESP:  if (w_r_hs)         w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from state only, so an asynchronous reset zeroes them at once.
  always_comb begin
    mst_reqst_rdy_o = '0;
    mst_resp_val_o  = '0;
    mst_resp_data_o = '0;
    slv_ar_valid_o  = 1'b0;
    slv_ar_addr_o   = '0;
    slv_r_ready_o   = 1'b0;
    case (r_state)
      S_ADDR: begin
        slv_ar_valid_o  = 1'b1;
        slv_ar_addr_o   = mst_reqst_addr_i[r_gidx*ADDR_WIDTH +: ADDR_WIDTH];
        mst_reqst_rdy_o = r_grant & {NUM_MASTERS{slv_ar_ready_i}};
      end
      S_RESP: begin
        mst_resp_val_o  = r_grant & {NUM_MASTERS{slv_r_valid_i}};
        slv_r_ready_o   = mst_resp_rdy_i[r_gidx];
        mst_resp_data_o = slv_r_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) r_age[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (w_any_req) begin
          r_grant <= NUM_MASTERS'(1) << w_win_idx;
          r_gidx  <= w_win_idx;
        end
        // Ages move only in arbitration cycles; absent requesters and the winner restart.
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (!mst_reqst_val_i[i] || (w_win_idx == IDX_W'(i))) begin
            r_age[i] <= '0;
          end else if (r_age[i] < 4'(AGE_LIMIT)) begin
            r_age[i] <= r_age[i] + 4'd1;
          end
        end
      end
      if (w_r_hs) begin
        r_grant  <= '0;
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_liteic_slave_read_arbiter.sv
// tb/tb_liteic_slave_read_arbiter.sv - directed self-checking bench for liteic_slave_read_arbiter
module tb_liteic_slave_read_arbiter;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic [3:0]   mst_reqst_val_i;
  logic [127:0] mst_reqst_addr_i;
  logic [15:0]  mst_reqst_qos_i;
  logic [3:0]   mst_reqst_rdy_o;
  logic [3:0]   mst_resp_val_o;
  logic [3:0]   mst_resp_rdy_i;
  logic [33:0]  mst_resp_data_o;
  logic         slv_ar_valid_o;
  logic         slv_ar_ready_i;
  logic [31:0]  slv_ar_addr_o;
  logic         slv_r_valid_i;
  logic         slv_r_ready_o;
  logic [33:0]  slv_r_data_i;
  logic [3:0]   grant_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  liteic_slave_read_arbiter #(
    .NUM_MASTERS(4), .ADDR_WIDTH(32), .RDATA_WIDTH(34), .AGE_LIMIT(2)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .mst_reqst_val_i(mst_reqst_val_i), .mst_reqst_addr_i(mst_reqst_addr_i),
    .mst_reqst_qos_i(mst_reqst_qos_i), .mst_reqst_rdy_o(mst_reqst_rdy_o),
    .mst_resp_val_o(mst_resp_val_o), .mst_resp_rdy_i(mst_resp_rdy_i),
    .mst_resp_data_o(mst_resp_data_o),
    .slv_ar_valid_o(slv_ar_valid_o), .slv_ar_ready_i(slv_ar_ready_i), .slv_ar_addr_o(slv_ar_addr_o),
    .slv_r_valid_i(slv_r_valid_i), .slv_r_ready_o(slv_r_ready_o), .slv_r_data_i(slv_r_data_i),
    .grant_o(grant_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    mst_reqst_val_i  = '0;
    mst_reqst_qos_i  = '0;
    mst_resp_rdy_i   = '0;
    slv_ar_ready_i   = 1'b0;
    slv_r_valid_i    = 1'b0;
    slv_r_data_i     = '0;
    mst_reqst_addr_i = {32'h0000_A003, 32'h0000_A002, 32'h0000_A001, 32'h0000_A000};
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn_i = 1'b0;
    step();
    step();
    rstn_i = 1'b1;
    #1;
  endtask

  // Returns the next fresh grant (seen in its ADDR cycle), or 0 if none appears in time.
  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int n = 0; n < 20 && grant_o != 4'b0; n++) step();
    for (int n = 0; n < 20; n++) begin
      step();
      if (grant_o != 4'b0) begin
        g = grant_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn_i          = 1'b0;
    mst_reqst_val_i = 4'b1111;
    mst_resp_rdy_i  = 4'b1111;
    slv_ar_ready_i  = 1'b1;
    slv_r_valid_i   = 1'b1;
    slv_r_data_i    = 34'h3_5555_AAAA;
    step();
    step();
    checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant_o); end
    checks++; if (slv_ar_valid_o !== 1'b0) begin errors++; $display("FAIL reset_ar_valid: got %b expected 0", slv_ar_valid_o); end
    checks++; if (slv_ar_addr_o !== 32'h0) begin errors++; $display("FAIL reset_ar_addr: got %h expected 0", slv_ar_addr_o); end
    checks++; if (mst_reqst_rdy_o !== 4'b0) begin errors++; $display("FAIL reset_reqst_rdy: got %b expected 0000", mst_reqst_rdy_o); end
    checks++; if (mst_resp_val_o !== 4'b0) begin errors++; $display("FAIL reset_resp_val: got %b expected 0000", mst_resp_val_o); end
    checks++; if (slv_r_ready_o !== 1'b0) begin errors++; $display("FAIL reset_r_ready: got %b expected 0", slv_r_ready_o); end
    checks++; if (mst_resp_data_o !== 34'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", mst_resp_data_o); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    mst_reqst_val_i                = 4'b0100;
    mst_reqst_addr_i[2*32 +: 32]   = 32'h0000_1000;
    mst_resp_rdy_i                 = 4'b1111;
    slv_ar_ready_i                 = 1'b1;
    #1;
    checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL single_idle_grant: got %b expected 0000", grant_o); end
    step();
    checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", grant_o); end
    checks++; if (slv_ar_valid_o !== 1'b1) begin errors++; $display("FAIL single_ar_valid: got %b expected 1", slv_ar_valid_o); end
    checks++; if (slv_ar_addr_o !== 32'h0000_1000) begin errors++; $display("FAIL single_ar_addr: got %h expected 00001000", slv_ar_addr_o); end
    checks++; if (mst_reqst_rdy_o !== 4'b0100) begin errors++; $display("FAIL single_reqst_rdy: got %b expected 0100", mst_reqst_rdy_o); end
    mst_reqst_val_i = 4'b0000;
    step();
    checks++; if (slv_ar_valid_o !== 1'b0) begin errors++; $display("FAIL single_resp_ar_valid: got %b expected 0", slv_ar_valid_o); end
    slv_r_valid_i = 1'b1;
    slv_r_data_i  = 34'h2_1234_5678;
    #1;
    checks++; if (mst_resp_val_o !== 4'b0100) begin errors++; $display("FAIL single_resp_val: got %b expected 0100", mst_resp_val_o); end
    checks++; if (mst_resp_data_o !== 34'h2_1234_5678) begin errors++; $display("FAIL single_resp_data: got %h expected 212345678", mst_resp_data_o); end
    checks++; if (slv_r_ready_o !== 1'b1) begin errors++; $display("FAIL single_r_ready: got %b expected 1", slv_r_ready_o); end
    step();
    slv_r_valid_i = 1'b0;
    #1;
    checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL single_back_idle: got %b expected 0000", grant_o); end
    checks++; if (mst_resp_val_o !== 4'b0) begin errors++; $display("FAIL single_idle_resp_val: got %b expected 0000", mst_resp_val_o); end
  endtask

  task automatic test_qos();
    logic [3:0] g;
    do_reset();
    mst_reqst_val_i = 4'b1001;
    mst_reqst_qos_i = {4'd9, 4'd0, 4'd0, 4'd1};
    mst_resp_rdy_i  = 4'b1111;
    slv_ar_ready_i  = 1'b1;
    slv_r_valid_i   = 1'b1;
    wait_grant(g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL qos_first: got %b expected 1000", g); end
    mst_reqst_val_i = 4'b0001;
    wait_grant(g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL qos_second: got %b expected 0001", g); end
    mst_reqst_val_i = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    mst_reqst_val_i = 4'b1111;
    mst_resp_rdy_i  = 4'b1111;
    slv_ar_ready_i  = 1'b1;
    slv_r_valid_i   = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g);
      checks++;
      if (g !== exp_g[n]) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, g, exp_g[n]); end
    end
    mst_reqst_val_i = 4'b0000;
  endtask

  task automatic test_aging();
    logic [3:0] g;
    logic [3:0] exp_g [3];
    exp_g = '{4'b0001, 4'b0001, 4'b0010};
    do_reset();
    mst_reqst_val_i = 4'b0011;
    mst_reqst_qos_i = {4'd0, 4'd0, 4'd0, 4'd15};
    mst_resp_rdy_i  = 4'b1111;
    slv_ar_ready_i  = 1'b1;
    slv_r_valid_i   = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_grant(g);
      checks++;
      if (g !== exp_g[n]) begin errors++; $display("FAIL aging_grant%0d: got %b expected %b", n, g, exp_g[n]); end
    end
    mst_reqst_val_i = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    mst_reqst_val_i = 4'b0110;
    #1;
    step();
    for (int n = 0; n < 5; n++) begin
      checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL bp_ar_grant%0d: got %b expected 0010", n, grant_o); end
      checks++; if (slv_ar_valid_o !== 1'b1 || slv_ar_addr_o !== 32'h0000_A001) begin
        errors++; $display("FAIL bp_ar_chan%0d: got valid %b addr %h expected 1 0000a001", n, slv_ar_valid_o, slv_ar_addr_o);
      end
      checks++; if (mst_reqst_rdy_o !== 4'b0 || mst_resp_val_o !== 4'b0) begin
        errors++; $display("FAIL bp_ar_quiet%0d: got rdy %b val %b expected 0000 0000", n, mst_reqst_rdy_o, mst_resp_val_o);
      end
      step();
    end
    slv_ar_ready_i = 1'b1;
    #1;
    checks++; if (mst_reqst_rdy_o !== 4'b0010) begin errors++; $display("FAIL bp_ar_rdy: got %b expected 0010", mst_reqst_rdy_o); end
    step();
    slv_ar_ready_i = 1'b0;
    slv_r_valid_i  = 1'b1;
    slv_r_data_i   = 34'h1_CAFE_F00D;
    mst_resp_rdy_i = 4'b0100;
    #1;
    for (int n = 0; n < 3; n++) begin
      checks++; if (mst_resp_val_o !== 4'b0010) begin errors++; $display("FAIL bp_r_val%0d: got %b expected 0010", n, mst_resp_val_o); end
      checks++; if (slv_r_ready_o !== 1'b0 || grant_o !== 4'b0010) begin
        errors++; $display("FAIL bp_r_hold%0d: got r_ready %b grant %b expected 0 0010", n, slv_r_ready_o, grant_o);
      end
      step();
    end
    mst_resp_rdy_i = 4'b0010;
    #1;
    checks++; if (slv_r_ready_o !== 1'b1) begin errors++; $display("FAIL bp_r_ready: got %b expected 1", slv_r_ready_o); end
    checks++; if (mst_resp_data_o !== 34'h1_CAFE_F00D) begin errors++; $display("FAIL bp_r_data: got %h expected 1cafef00d", mst_resp_data_o); end
    step();
    slv_r_valid_i = 1'b0;
    #1;
    checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0000", grant_o); end
    step();
    checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL bp_next_grant: got %b expected 0100", grant_o); end
    mst_reqst_val_i = 4'b0000;
  endtask

  task automatic test_reset_in_resp();
    logic [3:0] g;
    do_reset();
    mst_reqst_val_i = 4'b0001;
    mst_resp_rdy_i  = 4'b1111;
    slv_ar_ready_i  = 1'b1;
    slv_r_valid_i   = 1'b1;
    wait_grant(g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL rr_setup_grant: got %b expected 0001", g); end
    mst_reqst_val_i = 4'b0000;
    step();
    step();
    slv_r_valid_i   = 1'b0;
    mst_reqst_val_i = 4'b0100;
    #1;
    step();
    step();
    slv_r_valid_i   = 1'b1;
    slv_r_data_i    = 34'h0_1111_2222;
    mst_resp_rdy_i  = 4'b0000;
    mst_reqst_val_i = 4'b0000;
    #1;
    checks++; if (mst_resp_val_o !== 4'b0100) begin errors++; $display("FAIL rst_pre_resp_val: got %b expected 0100", mst_resp_val_o); end
    rstn_i         = 1'b0;
    mst_resp_rdy_i = 4'b1111;
    #1;
    checks++; if (grant_o !== 4'b0 || mst_resp_val_o !== 4'b0) begin
      errors++; $display("FAIL rst_resp_outputs: got grant %b val %b expected 0000 0000", grant_o, mst_resp_val_o);
    end
    checks++; if (slv_r_ready_o !== 1'b0 || mst_resp_data_o !== 34'h0 || slv_ar_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_resp_chan: got r_ready %b data %h ar_valid %b expected 0 0 0", slv_r_ready_o, mst_resp_data_o, slv_ar_valid_o);
    end
    step();
    mst_reqst_val_i = 4'b0101;
    rstn_i          = 1'b1;
    #1;
    checks++; if (mst_resp_val_o !== 4'b0) begin errors++; $display("FAIL rst_no_stale_beat: got %b expected 0000", mst_resp_val_o); end
    step();
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL rst_rr_from_zero: got %b expected 0001", grant_o); end
    mst_reqst_val_i = 4'b0000;
  endtask

  initial begin
    clear_inputs();
    rstn_i = 1'b0;
    test_reset();
    test_single();
    test_qos();
    test_round_robin();
    test_aging();
    test_backpressure();
    test_reset_in_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
